// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters and saturating hit/mispredict performance counters. Lookup has no
// latency. Updates from the resolving stage take effect at the next edge.
module branch_predictor_btb #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int DYNAMIC = 1,
  parameter int PERF_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              lookup_en,
  input  logic [31:0]       lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              update_en,
  input  logic [31:0]       update_pc,
  input  logic              update_taken,
  input  logic [31:0]       update_target,
  input  logic              update_mispredict,
  output logic [PERF_W-1:0] perf_hits,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

  function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
    return (c == {CTR_W{1'b1}}) ? c : c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] c);
    return (c == {PERF_W{1'b1}}) ? c : c + PERF_W'(1);
  endfunction

  // Table state is held in flops so every entry can be cleared by reset.
  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];

  logic [PERF_W-1:0] perf_hits_q, perf_hits_d;
  logic [PERF_W-1:0] perf_mis_q,  perf_mis_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, up_we;
  logic [CTR_W-1:0] up_ctr_d;
  logic [31:0]      up_tgt_d;

  // Byte-offset bits of both PCs play no part in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[31:IDX_W+2];

  // Zero-latency lookup; an update in flight this cycle is not yet visible.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = (DYNAMIC != 0) && pred_hit && ctr_q[lk_idx][CTR_W-1];
    pred_target = pred_taken ? tgt_q[lk_idx] : lookup_pc + 32'd4;
  end

  // Next state of the indexed entry: train on a tag hit, allocate on a taken miss.
  always_comb begin
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_we    = 1'b0;
    up_ctr_d = ctr_q[up_idx];
    up_tgt_d = tgt_q[up_idx];
    if (update_en) begin
      if (up_hit) begin
        up_we = 1'b1;
        if (update_taken) begin
          up_ctr_d = ctr_inc(ctr_q[up_idx]);
          up_tgt_d = update_target;
        end else begin
          up_ctr_d = ctr_dec(ctr_q[up_idx]);
        end
      end else if (update_taken) begin
        up_we    = 1'b1;
        up_ctr_d = CTR_WT;
        up_tgt_d = update_target;
      end
    end
  end

  // Table write; a taken miss evicts whatever occupied the index.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (up_we) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      tgt_q[up_idx]   <= up_tgt_d;
      ctr_q[up_idx]   <= up_ctr_d;
    end
  end

  // Performance counter next state; both may advance in the same cycle.
  always_comb begin
    perf_hits_d = perf_hits_q;
    perf_mis_d  = perf_mis_q;
    if (lookup_en && pred_hit)          perf_hits_d = perf_inc(perf_hits_q);
    if (update_en && update_mispredict) perf_mis_d  = perf_inc(perf_mis_q);
  end

  // Performance counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_hits_q <= '0;
      perf_mis_q  <= '0;
    end else begin
      perf_hits_q <= perf_hits_d;
      perf_mis_q  <= perf_mis_d;
    end
  end

  assign perf_hits        = perf_hits_q;
  assign perf_mispredicts = perf_mis_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb. A default instance and a static
// (DYNAMIC=0, PERF_W=4) instance share every input. Expected values are
// queued as stimulus is applied and popped as the outputs are sampled.
module tb_branch_predictor_btb;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;

  logic        hit_a, taken_a;
  logic [31:0] target_a;
  logic [15:0] phits_a, pmis_a;
  logic        hit_s, taken_s;
  logic [31:0] target_s;
  logic [3:0]  phits_s, pmis_s;

  branch_predictor_btb u_dut (
    .CLK(CLK), .nRST(nRST), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_hit(hit_a), .pred_taken(taken_a), .pred_target(target_a),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .perf_hits(phits_a), .perf_mispredicts(pmis_a)
  );

  branch_predictor_btb #(.ENTRIES(16), .CTR_W(2), .DYNAMIC(0), .PERF_W(4)) u_dut_s (
    .CLK(CLK), .nRST(nRST), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_hit(hit_s), .pred_taken(taken_s), .pred_target(target_s),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .perf_hits(phits_s), .perf_mispredicts(pmis_s)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0x%08h expected none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Lookup both instances; the static one must never predict taken.
  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt);
    lookup_pc = pc;
    expect_val({tag, ".hit"}, {31'd0, hit});
    expect_val({tag, ".taken"}, {31'd0, tk});
    expect_val({tag, ".target"}, tgt);
    expect_val({tag, ".s_hit"}, {31'd0, hit});
    expect_val({tag, ".s_taken"}, 32'd0);
    expect_val({tag, ".s_target"}, pc + 32'd4);
    #1;
    check_next({31'd0, hit_a});
    check_next({31'd0, taken_a});
    check_next(target_a);
    check_next({31'd0, hit_s});
    check_next({31'd0, taken_s});
    check_next(target_s);
  endtask

  task automatic perf(input string tag, input logic [15:0] h, input logic [15:0] m,
                      input logic [3:0] hs, input logic [3:0] ms);
    expect_val({tag, ".hits"}, {16'd0, h});
    expect_val({tag, ".mis"}, {16'd0, m});
    expect_val({tag, ".s_hits"}, {28'd0, hs});
    expect_val({tag, ".s_mis"}, {28'd0, ms});
    #1;
    check_next({16'd0, phits_a});
    check_next({16'd0, pmis_a});
    check_next({28'd0, phits_s});
    check_next({28'd0, pmis_s});
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic mis);
    update_en         = 1'b1;
    update_pc         = pc;
    update_taken      = tk;
    update_target     = tgt;
    update_mispredict = mis;
    tick();
    update_en         = 1'b0;
    update_mispredict = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0; lookup_en = 1'b0; lookup_pc = 32'h40;
    update_en = 1'b0; update_pc = '0; update_taken = 1'b0;
    update_target = '0; update_mispredict = 1'b0;
    #1;
    look("reset", 32'h40, 1'b0, 1'b0, 32'h44);
    perf("reset", 16'd0, 16'd0, 4'd0, 4'd0);
    #25 nRST = 1'b1;
    tick();

    // Allocation, then decay to strongly not-taken.
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look("ctr0", 32'h40, 1'b1, 1'b0, 32'h44);

    // Climb to 2, then three more taken must saturate at 3.
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b1, 32'h104, 1'b0);
    look("sat3", 32'h40, 1'b1, 1'b1, 32'h104);
    upd(32'h40, 1'b0, 32'h999, 1'b0);
    look("ctr2", 32'h40, 1'b1, 1'b1, 32'h104);
    upd(32'h40, 1'b0, 32'h999, 1'b0);
    look("ctr1", 32'h40, 1'b1, 1'b0, 32'h44);

    // Not-taken at a miss leaves the table alone.
    upd(32'h200, 1'b0, 32'h777, 1'b0);
    look("nt_miss", 32'h200, 1'b0, 1'b0, 32'h204);
    look("nt_miss_keep", 32'h40, 1'b1, 1'b0, 32'h44);

    // Aliasing on index 0 evicts the older tag.
    upd(32'h80, 1'b1, 32'h300, 1'b0);
    look("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias_new", 32'h80, 1'b1, 1'b1, 32'h300);

    // Same-cycle lookup and update: old state now, new state next cycle.
    update_en = 1'b1; update_pc = 32'h40; update_taken = 1'b1;
    update_target = 32'h140; update_mispredict = 1'b0;
    look("same_cyc", 32'h40, 1'b0, 1'b0, 32'h44);
    tick();
    update_en = 1'b0;
    look("same_next", 32'h40, 1'b1, 1'b1, 32'h140);
    look("pc_lsbs", 32'h43, 1'b1, 1'b1, 32'h140);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // Hit counter: three enabled hits, two enabled misses.
    perf("pre_hits", 16'd0, 16'd0, 4'd0, 4'd0);
    lookup_en = 1'b1; lookup_pc = 32'h40;
    tick(); tick(); tick();
    lookup_pc = 32'h200;
    tick(); tick();
    lookup_en = 1'b0;
    perf("hits", 16'd3, 16'd0, 4'd3, 4'd0);

    // Mispredict flag without update_en is ignored; then 17 real ones.
    update_mispredict = 1'b1;
    tick(); tick();
    update_mispredict = 1'b0;
    perf("mis_gated", 16'd3, 16'd0, 4'd3, 4'd0);
    for (int i = 0; i < 17; i++) upd(32'h200, 1'b0, 32'h0, 1'b1);
    perf("mis_sat", 16'd3, 16'd17, 4'd3, 4'd15);
    look("mis_keep", 32'h40, 1'b1, 1'b1, 32'h140);

    // Reset arriving while an update is pending discards it.
    update_en = 1'b1; update_pc = 32'h80; update_taken = 1'b1;
    update_target = 32'h500; update_mispredict = 1'b1;
    #3 nRST = 1'b0;
    perf("rst_async", 16'd0, 16'd0, 4'd0, 4'd0);
    look("rst_40", 32'h40, 1'b0, 1'b0, 32'h44);
    tick();
    update_en = 1'b0; update_mispredict = 1'b0;
    #2 nRST = 1'b1;
    tick();
    look("rst_80", 32'h80, 1'b0, 1'b0, 32'h84);
    look("rst_40b", 32'h40, 1'b0, 1'b0, 32'h44);
    perf("rst_after", 16'd0, 16'd0, 4'd0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
